// File: rtl/dmem_pkg.sv
// Shared definitions for the clocked data memory: RISC-V funct3 size codes
// and the request/response FSM states.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for the data memory: store byte enables and replicated
// data, misalign/illegal-size detection, and load extraction with extension.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] raw_word,
    output logic [3:0]  byte_en,
    output logic [31:0] wdata_rep,
    output logic        bad,
    output logic [31:0] load_data
);

    logic [31:0] shifted;

    // Unsigned codes are legal only for loads, so a store with them is flagged.
    always_comb begin
        byte_en   = '0;
        wdata_rep = '0;
        bad       = 1'b0;
        case (funct3)
            F3_B: begin
                byte_en   = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
            end
            F3_H: begin
                byte_en   = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata[15:0]}};
                bad       = addr_lo[0];
            end
            F3_W: begin
                byte_en   = 4'b1111;
                wdata_rep = wdata;
                bad       = |addr_lo;
            end
            F3_BU:   bad = we;
            F3_HU:   bad = we | addr_lo[0];
            default: bad = 1'b1;
        endcase
    end

    always_comb begin
        shifted   = raw_word >> {addr_lo, 3'b000};
        load_data = '0;
        case (funct3)
            F3_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
            F3_W:    load_data = raw_word;
            F3_BU:   load_data = {24'h0, shifted[7:0]};
            F3_HU:   load_data = {16'h0, shifted[15:0]};
            default: load_data = '0;
        endcase
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Clocked data memory for the load/store unit: one outstanding request,
// configurable read latency, byte/half/word access with error reporting.
module data_mem_ctrl
    import dmem_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int DEPTH        = 128,
    parameter int ADDR_W       = 9,
    parameter int READ_LAT     = 1,
    parameter int INIT_PATTERN = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int IDX_W = $clog2(DEPTH);

    typedef logic [31:0] mem_t [DEPTH];

    function automatic mem_t init_mem();
        mem_t m;
        for (int i = 0; i < DEPTH; i++) begin
            m[i] = (INIT_PATTERN == 1) ? 32'(i) : 32'h0;
        end
        return m;
    endfunction

    // Power-up contents only; reset deliberately leaves the array alone.
    mem_t mem = init_mem();

    state_t             state;
    state_t             state_next;
    logic [1:0]         cnt;
    logic               accept;
    logic [ADDR_W-3:0]  word_idx;
    logic               out_of_range;
    logic [31:0]        raw_word;
    logic [3:0]         byte_en;
    logic [31:0]        wdata_rep;
    logic               bad;
    logic               err;
    logic [31:0]        load_data;

    assign word_idx     = req_addr[ADDR_W-1:2];
    assign out_of_range = 32'(word_idx) >= 32'(DEPTH);
    assign raw_word     = out_of_range ? 32'h0 : mem[word_idx[IDX_W-1:0]];
    assign err          = bad | out_of_range;
    assign accept       = req_valid & req_ready;

    dmem_lane_align u_align (
        .we        (req_we),
        .funct3    (req_funct3),
        .addr_lo   (req_addr[1:0]),
        .wdata     (req_wdata),
        .raw_word  (raw_word),
        .byte_en   (byte_en),
        .wdata_rep (wdata_rep),
        .bad       (bad),
        .load_data (load_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_next = (READ_LAT == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (cnt == 2'd1) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= 2'(READ_LAT - 1);
        end else if (state == WAIT && cnt != 2'd0) begin
            cnt <= cnt - 1'b1;
        end
    end

    // The result is fixed at accept time so later stores cannot disturb it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else if (accept) begin
            rsp_err   <= err;
            rsp_rdata <= (err || req_we) ? '0 : load_data;
        end
    end

    // rst_n gating matters: req_ready is high throughout reset.
    always_ff @(posedge clk) begin
        if (rst_n && accept && req_we && !err) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    mem[word_idx[IDX_W-1:0]][8*i +: 8] <= wdata_rep[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: a READ_LAT=1 instance for the
// access-type table and a READ_LAT=3 instance for stall and reset sequences.
module tb_data_mem_ctrl;
    import dmem_pkg::*;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          sel = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_we = 1'b0;
    logic [2:0]    req_funct3 = 3'b000;
    logic [AW-1:0] req_addr = '0;
    logic [31:0]   req_wdata = '0;
    logic          rsp_ready = 1'b1;

    logic          req_valid1, req_valid3;
    logic          req_ready1, req_ready3, rsp_valid1, rsp_valid3, rsp_err1, rsp_err3;
    logic [31:0]   rsp_rdata1, rsp_rdata3;
    logic          req_ready, rsp_valid, rsp_err;
    logic [31:0]   rsp_rdata;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    assign req_valid1 = req_valid & ~sel;
    assign req_valid3 = req_valid & sel;
    assign req_ready  = sel ? req_ready3 : req_ready1;
    assign rsp_valid  = sel ? rsp_valid3 : rsp_valid1;
    assign rsp_rdata  = sel ? rsp_rdata3 : rsp_rdata1;
    assign rsp_err    = sel ? rsp_err3   : rsp_err1;

    data_mem_ctrl #(.DEPTH(128), .ADDR_W(AW), .READ_LAT(1), .INIT_PATTERN(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid1), .req_ready(req_ready1),
        .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err1)
    );

    data_mem_ctrl #(.DEPTH(128), .ADDR_W(AW), .READ_LAT(3), .INIT_PATTERN(1)) dut3 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid3), .req_ready(req_ready3),
        .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata3), .rsp_err(rsp_err3)
    );

    typedef struct {
        logic          we;
        logic [2:0]    f3;
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
        logic [31:0]   exp_rdata;
        logic          exp_err;
        string         name;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Pushes the expected response, then holds the request until accepted.
    task automatic applyStimulus(input vec_t v, output bit ok);
        int n;
        sb.push_back('{v.exp_rdata, v.exp_err});
        @(posedge clk); #1;
        req_valid  = 1'b1;
        req_we     = v.we;
        req_funct3 = v.f3;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        n = 0;
        while (!req_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!req_ready) begin
            tests++;
            fails++;
            $display("[TB] FAIL %s accept: req_ready never rose", v.name);
            req_valid = 1'b0;
            ok = 1'b0;
            return;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        ok = 1'b1;
    endtask

    // Called one step after the accept edge; waits for and checks the response.
    task automatic checkOutput(input string name, input int exp_lat);
        int   lat;
        exp_t e;
        lat = 1;
        while (!rsp_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        e = sb.pop_front();
        if (!rsp_valid) begin
            tests++;
            fails++;
            $display("[TB] FAIL %s response: rsp_valid never rose", name);
            return;
        end
        check({name, " latency"}, 32'(lat), 32'(exp_lat));
        check({name, " rdata"}, rsp_rdata, e.rdata);
        check({name, " err"}, 32'(rsp_err), 32'(e.err));
        check({name, " no req_ready in RESP"}, 32'(req_ready), 32'd0);
        if (rsp_ready) begin
            @(posedge clk); #1;
            check({name, " consumed"}, 32'(rsp_valid), 32'd0);
        end
    endtask

    task automatic runVec(input vec_t v, input int lat);
        bit ok;
        applyStimulus(v, ok);
        if (ok) checkOutput(v.name, lat);
        else void'(sb.pop_front());
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, %0d tests run", tests);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit   ok;
        int   lat;
        exp_t e;

        tbl.push_back('{1'b0, F3_W,   10'h014, 32'h0,        32'h00000005, 1'b0, "lw_init"});
        tbl.push_back('{1'b1, F3_W,   10'h020, 32'h800000F0, 32'h00000000, 1'b0, "sw_0x20"});
        tbl.push_back('{1'b0, F3_B,   10'h020, 32'h0,        32'hFFFFFFF0, 1'b0, "lb_0x20"});
        tbl.push_back('{1'b0, F3_BU,  10'h020, 32'h0,        32'h000000F0, 1'b0, "lbu_0x20"});
        tbl.push_back('{1'b0, F3_H,   10'h022, 32'h0,        32'hFFFF8000, 1'b0, "lh_0x22"});
        tbl.push_back('{1'b0, F3_HU,  10'h022, 32'h0,        32'h00008000, 1'b0, "lhu_0x22"});
        tbl.push_back('{1'b1, F3_B,   10'h031, 32'h123456AA, 32'h00000000, 1'b0, "sb_0x31"});
        tbl.push_back('{1'b0, F3_W,   10'h030, 32'h0,        32'h0000AA0C, 1'b0, "lw_0x30"});
        tbl.push_back('{1'b0, F3_BU,  10'h031, 32'h0,        32'h000000AA, 1'b0, "lbu_0x31"});
        tbl.push_back('{1'b1, F3_H,   10'h011, 32'h0000ABCD, 32'h00000000, 1'b1, "sh_misaligned"});
        tbl.push_back('{1'b0, F3_W,   10'h010, 32'h0,        32'h00000004, 1'b0, "lw_0x10_unchanged"});
        tbl.push_back('{1'b0, F3_W,   10'h200, 32'h0,        32'h00000000, 1'b1, "lw_out_of_range"});
        tbl.push_back('{1'b0, 3'b011, 10'h000, 32'h0,        32'h00000000, 1'b1, "illegal_f3"});
        tbl.push_back('{1'b1, F3_H,   10'h012, 32'h5555BEEF, 32'h00000000, 1'b0, "sh_0x12"});
        tbl.push_back('{1'b0, F3_W,   10'h010, 32'h0,        32'hBEEF0004, 1'b0, "lw_0x10_half"});
        tbl.push_back('{1'b0, F3_H,   10'h012, 32'h0,        32'hFFFFBEEF, 1'b0, "lh_0x12"});
        tbl.push_back('{1'b0, F3_W,   10'h002, 32'h0,        32'h00000000, 1'b1, "lw_misaligned"});
        tbl.push_back('{1'b1, F3_BU,  10'h050, 32'hFFFFFFFF, 32'h00000000, 1'b1, "store_bu_illegal"});
        tbl.push_back('{1'b0, F3_W,   10'h050, 32'h0,        32'h00000014, 1'b0, "lw_0x50_unchanged"});

        #2 rst_n = 1'b0;
        #2;
        check("reset rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset req_ready", 32'(req_ready), 32'd1);
        check("reset rsp_rdata", rsp_rdata, 32'h0);
        check("reset rsp_err", 32'(rsp_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        sel = 1'b0;
        for (int i = 0; i < tbl.size(); i++) begin
            runVec(tbl[i], 1);
        end

        // Stalled response on the latency-3 instance with a competing request.
        sel = 1'b1;
        rsp_ready = 1'b0;
        applyStimulus('{1'b0, F3_W, 10'h008, 32'h0, 32'h00000002, 1'b0, "lw_0x08_stall"}, ok);
        if (ok) begin
            lat = 1;
            while (!rsp_valid && lat < 50) begin
                @(posedge clk); #1;
                lat++;
            end
            e = sb.pop_front();
            check("stall latency", 32'(lat), 32'd3);
            req_valid  = 1'b1;
            req_we     = 1'b1;
            req_funct3 = F3_W;
            req_addr   = 10'h008;
            req_wdata  = 32'hDEADBEEF;
            for (int c = 0; c < 4; c++) begin
                check("stall rsp_valid", 32'(rsp_valid), 32'd1);
                check("stall rsp_rdata", rsp_rdata, e.rdata);
                check("stall rsp_err", 32'(rsp_err), 32'(e.err));
                check("stall req_ready", 32'(req_ready), 32'd0);
                @(posedge clk); #1;
            end
            req_valid = 1'b0;
            rsp_ready = 1'b1;
            @(posedge clk); #1;
            check("stall released", 32'(rsp_valid), 32'd0);
        end else begin
            void'(sb.pop_front());
        end
        rsp_ready = 1'b1;
        runVec('{1'b0, F3_W, 10'h008, 32'h0, 32'h00000002, 1'b0, "lw_0x08_no_store"}, 3);

        // Reset while waiting: store stays committed, response is dropped.
        applyStimulus('{1'b1, F3_W, 10'h040, 32'h12345678, 32'h0, 1'b0, "sw_0x40"}, ok);
        void'(sb.pop_front());
        rst_n = 1'b0;
        #1;
        check("midreset rsp_valid", 32'(rsp_valid), 32'd0);
        check("midreset req_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        check("midreset held rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        runVec('{1'b0, F3_W, 10'h040, 32'h0, 32'h12345678, 1'b0, "lw_0x40_after_reset"}, 3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
- Parametrised, clocked successor to the single-cycle data memory, for the load/store unit of the next RISC-V core.
- Takes byte addresses and a RISC-V funct3 size code.
- Supports byte, half and word loads and stores, with sign or zero extension and byte-lane write enables.
- Flags misaligned and out-of-range accesses; read latency is configurable; one request outstanding, with valid/ready handshakes on request and response.

Parameters:
- DATA_W, 32, data width; fixed at 32 (RV32); other values are illegal.
- DEPTH, 128, number of 32-bit words.
- ADDR_W, 9, byte-address width; must satisfy 4*DEPTH <= 2**ADDR_W.
- READ_LAT, 1, cycles from request acceptance to rsp_valid; legal range 1..4.
- INIT_PATTERN, 1, simulation init: 1 gives word i = i; 0 gives all words 0.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- req_valid, input, 1, request present.
- req_ready, output, 1, request accepted on the edge where req_valid and req_ready are both 1.
- req_we, input, 1, 1 = store, 0 = load.
- req_funct3, input, 3, RISC-V size/sign code.
- req_addr, input, ADDR_W, byte address.
- req_wdata, input, 32, store data; right-aligned for SB/SH.
- rsp_valid, output, 1, response present.
- rsp_ready, input, 1, consumer accepts the response.
- rsp_rdata, output, 32, load result, extended; 0 for stores and errors.
- rsp_err, output, 1, access was misaligned, out of range or illegal funct3.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, latency counter=0.
  - Memory contents are not cleared by reset.
- FSM states:
  - IDLE: req_ready=1. On accept, go to WAIT, load counter=READ_LAT-1, capture result into the response register.
  - WAIT: req_ready=0. Counter decrements each cycle; when it reaches 0, go to RESP.
  - RESP: rsp_valid=1. Go to IDLE on the edge where rsp_ready=1.
  - Net effect: rsp_valid rises READ_LAT edges after the accept edge. With READ_LAT=1, WAIT lasts zero cycles: go IDLE->RESP directly.
- Throughput: at most one request per READ_LAT+1 cycles. No new request is accepted until the response completes; rsp_valid=1 and req_ready=1 never coincide.
- Decode at accept:
  - Word index = req_addr[ADDR_W-1:2].
  - Legal loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Legal stores: 000 SB, 001 SH, 010 SW.
  - Any other funct3 is illegal and sets err.
- Alignment: half needs addr[0]=0; word needs addr[1:0]=0. Otherwise err.
- Range: word index >= DEPTH sets err.
- Stores:
  - Memory is written on the accept edge when no err; little-endian.
  - SB writes lane addr[1:0]; SH writes lanes {addr[1],0} and {addr[1],1}; SW writes all 4 lanes.
  - Unselected bytes are unchanged.
  - On err, memory is unchanged.
- Loads:
  - Data is read on the accept edge and extracted from lane addr[1:0].
  - LB/LH sign-extend; LBU/LHU zero-extend.
- Response register: rsp_rdata and rsp_err are held stable while rsp_valid=1 and rsp_ready=0.
- Reset mid-operation:
  - Any pending response is dropped; FSM returns to IDLE.
  - A store already accepted stays committed.
  - No write occurs on an edge where rst_n=0.

Decomposition:
- Package dmem_pkg:
  - funct3 constants F3_B=3'b000, F3_H=3'b001, F3_W=3'b010, F3_BU=3'b100, F3_HU=3'b101.
  - State enum IDLE/WAIT/RESP.
- Sub-module dmem_lane_align (combinational). From funct3, addr[1:0] and wdata it produces:
  - byte enables [3:0];
  - replicated store data;
  - misalign/illegal flag;
  - load extract and extend from the raw 32-bit word.
- Top holds the memory array, FSM, counter and response register.

Test Plan:
- Reset with INIT_PATTERN=1, READ_LAT=1; LW addr 0x014 -> next cycle rsp_valid=1, rsp_rdata=0x00000005, rsp_err=0.
- SW 0x800000F0 @0x020, then:
  - LB 0x020 -> 0xFFFFFFF0;
  - LBU 0x020 -> 0x000000F0;
  - LH 0x022 -> 0xFFFF8000;
  - LHU 0x022 -> 0x00008000.
- SB 0xAA @0x031, then LW 0x030 -> 0x0000AA0C.
- SH 0xABCD @0x011 -> rsp_err=1; then LW 0x010 -> 0x00000004, memory unchanged.
- LW 0x200 (DEPTH=128) -> rsp_err=1, rsp_rdata=0.
- funct3=3'b011 -> rsp_err=1.
- READ_LAT=3, LW 0x008:
  - rsp_valid rises exactly 3 edges after accept;
  - hold rsp_ready=0 for 4 cycles -> rsp_valid, rsp_rdata=0x00000002 stable; req_ready=0; a second req_valid is not accepted.
- SW 0x12345678 @0x040, assert rst_n=0 during WAIT -> rsp_valid=0, req_ready=1 immediately; after release, LW 0x040 -> 0x12345678.
